// File: rtl/calib_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : calib_led_pattern_gen
//  Purpose  : Answers the calibration sequencer's LED-select interface. A
//             start pulse latches which LED-address bit to display. One colour
//             beat per LED is then streamed to the strip driver: an LED is lit
//             when that bit of its index is 1. The block then waits for the
//             driver's frame_done and a camera settle time, and finally
//             raises led_display_valid_out.
//  Ports    : clk_in, rst_in (async, active high)
//             led_addr_bit_sel_in / led_addr_bit_sel_start_in : select + start
//             led_display_valid_out : pattern shown and settled
//             pixel_data/addr/valid/last_out, pixel_ready_in : pixel stream
//             frame_done_in : strip latch/reset time complete
//  Options  : `define CALIB_COMPLEMENT_PASS_EN adds complement_in. When it is
//             sampled high with start, lit/dark selection is inverted.
//  Revision : 1.0 - initial release
// ============================================================================
module calib_led_pattern_gen #(
    parameter int          NUM_LEDS               = 50,
    parameter int          LED_ADDRESS_WIDTH      = $clog2(NUM_LEDS),
    parameter int          LED_ADDR_BIT_SEL_WIDTH = $clog2(LED_ADDRESS_WIDTH),
    parameter logic [23:0] ON_COLOR               = 24'hFFFFFF,
    parameter logic [23:0] OFF_COLOR              = 24'h000000,
    parameter int          SETTLE_CYCLES          = 1000
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] led_addr_bit_sel_in,
    input  logic                              led_addr_bit_sel_start_in,
`ifdef CALIB_COMPLEMENT_PASS_EN
    input  logic                              complement_in,
`endif
    output logic                              led_display_valid_out,
    output logic [23:0]                       pixel_data_out,
    output logic [LED_ADDRESS_WIDTH-1:0]      pixel_addr_out,
    output logic                              pixel_valid_out,
    output logic                              pixel_last_out,
    input  logic                              pixel_ready_in,
    input  logic                              frame_done_in
);

    localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [LED_ADDRESS_WIDTH-1:0] c_last_addr = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
    localparam logic [LED_ADDRESS_WIDTH-1:0] c_addr_one  = LED_ADDRESS_WIDTH'(1);
    localparam logic [c_cnt_w-1:0]           c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]           c_settle_ld =
        (SETTLE_CYCLES > 0) ? c_cnt_w'(SETTLE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        STREAM     = 3'd1,
        WAIT_FRAME = 3'd2,
        SETTLE     = 3'd3,
        SHOWN      = 3'd4
    } state_t;

    state_t                              r_state;
    logic [LED_ADDR_BIT_SEL_WIDTH-1:0]   r_sel;
    logic                                r_comp;
    logic [LED_ADDRESS_WIDTH-1:0]        r_addr;
    logic [23:0]                         r_data;
    logic                                r_valid;
    logic                                r_last;
    logic [c_cnt_w-1:0]                  r_cnt;

    logic                                w_comp_start;
    logic                                w_xfer;
    logic [LED_ADDRESS_WIDTH-1:0]        w_addr_nxt;

`ifdef CALIB_COMPLEMENT_PASS_EN
    assign w_comp_start = complement_in;
`else
    assign w_comp_start = 1'b0;
`endif

    assign w_xfer     = r_valid && pixel_ready_in;
    assign w_addr_nxt = r_addr + c_addr_one;

    // Colour for one LED. The loop only compares against in-range bit
    // positions, so an out-of-range select never indexes past the address
    // and leaves the LED dark (or lit when the complement pass is active).
    function automatic logic [23:0] f_color(
        input logic [LED_ADDR_BIT_SEL_WIDTH-1:0] sel,
        input logic [LED_ADDRESS_WIDTH-1:0]      addr,
        input logic                              comp
    );
        logic lit;
        lit = 1'b0;
        for (int i = 0; i < LED_ADDRESS_WIDTH; i++) begin
            if (int'(sel) == i) begin
                lit = addr[i];
            end
        end
        return (lit ^ comp) ? ON_COLOR : OFF_COLOR;
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_comp  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
        end else if (led_addr_bit_sel_start_in) begin
            // A start aborts whatever is in progress and takes priority
            // over any transfer or frame_done in the same cycle.
            r_state <= STREAM;
            r_sel   <= led_addr_bit_sel_in;
            r_comp  <= w_comp_start;
            r_addr  <= '0;
            r_data  <= f_color(led_addr_bit_sel_in, '0, w_comp_start);
            r_valid <= 1'b1;
            r_last  <= (c_last_addr == '0);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                STREAM: begin
                    if (w_xfer) begin
                        if (r_addr == c_last_addr) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= WAIT_FRAME;
                        end else begin
                            // Next beat is precomputed so data/addr/last stay
                            // registered and hold while ready is low.
                            r_addr <= w_addr_nxt;
                            r_data <= f_color(r_sel, w_addr_nxt, r_comp);
                            r_last <= (w_addr_nxt == c_last_addr);
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (frame_done_in) begin
                        if (SETTLE_CYCLES == 0) begin
                            r_state <= SHOWN;
                        end else begin
                            r_cnt   <= c_settle_ld;
                            r_state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= SHOWN;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                IDLE, SHOWN: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Gated by the start input so the sequencer never sees a stale valid
    // in the same cycle it requests a new pattern.
    assign led_display_valid_out = (r_state == SHOWN) && !led_addr_bit_sel_start_in;
    assign pixel_data_out        = r_data;
    assign pixel_addr_out        = r_addr;
    assign pixel_valid_out       = r_valid;
    assign pixel_last_out        = r_last;

endmodule
`default_nettype wire

// File: tb/tb_calib_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calib_led_pattern_gen
//  Purpose  : Self-checking bench. Two instances share one stimulus stream:
//             dut_a settles for 3 cycles and dut_b for 0 cycles. Pixel beats
//             are compared against colours computed from the LED index.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calib_led_pattern_gen;

    localparam int N  = 5;
    localparam int AW = $clog2(N);
    localparam int SW = $clog2(AW);
    localparam int SA = 3;
    localparam logic [23:0] ON_C  = 24'hFFFFFF;
    localparam logic [23:0] OFF_C = 24'h000000;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [SW-1:0] sel;
    logic          start;
    logic          comp;
    logic          ready;
    logic          fdone;

    logic          dv_a, pv_a, pl_a;
    logic [23:0]   pd_a;
    logic [AW-1:0] pa_a;
    logic          dv_b, pv_b, pl_b;
    logic [23:0]   pd_b;
    logic [AW-1:0] pa_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    calib_led_pattern_gen #(
        .NUM_LEDS(N), .ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .SETTLE_CYCLES(SA)
    ) dut_a (
        .clk_in(clk_in), .rst_in(rst_in),
        .led_addr_bit_sel_in(sel), .led_addr_bit_sel_start_in(start),
`ifdef CALIB_COMPLEMENT_PASS_EN
        .complement_in(comp),
`endif
        .led_display_valid_out(dv_a), .pixel_data_out(pd_a),
        .pixel_addr_out(pa_a), .pixel_valid_out(pv_a), .pixel_last_out(pl_a),
        .pixel_ready_in(ready), .frame_done_in(fdone)
    );

    calib_led_pattern_gen #(
        .NUM_LEDS(N), .ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .SETTLE_CYCLES(0)
    ) dut_b (
        .clk_in(clk_in), .rst_in(rst_in),
        .led_addr_bit_sel_in(sel), .led_addr_bit_sel_start_in(start),
`ifdef CALIB_COMPLEMENT_PASS_EN
        .complement_in(comp),
`endif
        .led_display_valid_out(dv_b), .pixel_data_out(pd_b),
        .pixel_addr_out(pa_b), .pixel_valid_out(pv_b), .pixel_last_out(pl_b),
        .pixel_ready_in(ready), .frame_done_in(fdone)
    );

    // Reference colour: bit `s` of the LED index, inverted for a complement pass.
    function automatic logic [23:0] exp_color(input int s, input int c, input int idx);
        int lit;
        lit = (s < AW) ? ((idx >> s) & 1) : 0;
        if (c != 0) lit = 1 - lit;
        return (lit != 0) ? ON_C : OFF_C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pv_a"}, 32'(pv_a), 0);
        chk({tag, "_pv_b"}, 32'(pv_b), 0);
        chk({tag, "_pl_a"}, 32'(pl_a), 0);
        chk({tag, "_pl_b"}, 32'(pl_b), 0);
    endtask

    // Issue a one-cycle start. Display valid must already be low in this cycle.
    task automatic start_frame(input int s, input int c);
        @(negedge clk_in);
        sel   = SW'(s);
        comp  = c[0];
        start = 1'b1;
        ready = 1'b1;
        fdone = ($urandom_range(0, 1) == 1);
        #1;
        chk("start_gate_dv_a", 32'(dv_a), 0);
        chk("start_gate_dv_b", 32'(dv_b), 0);
    endtask

    // Consume beats until `stop_at` have transferred.
    // mode 0: ready high, 1: ready toggles 1,0,..., 2: random ready.
    task automatic collect(input int s, input int c, input int mode, input int stop_at);
        int e;
        bit done;
        e = 0;
        done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk_in);
            start = 1'b0;
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 2 == 0);
                default: ready = ($urandom_range(0, 2) != 0);
            endcase
            fdone = ($urandom_range(0, 3) == 0);
            #1;
            chk("stream_pv_a",   32'(pv_a), 1);
            chk("stream_pv_b",   32'(pv_b), 1);
            chk("stream_addr_a", 32'(pa_a), 32'(e));
            chk("stream_addr_b", 32'(pa_b), 32'(e));
            chk("stream_data_a", 32'(pd_a), 32'(exp_color(s, c, e)));
            chk("stream_data_b", 32'(pd_b), 32'(exp_color(s, c, e)));
            chk("stream_last_a", 32'(pl_a), 32'(e == N - 1));
            chk("stream_last_b", 32'(pl_b), 32'(e == N - 1));
            chk("stream_dv_a",   32'(dv_a), 0);
            if (ready) e++;
            if (e == stop_at) done = 1;
        end
        if (!done) chk("stream_timeout", 0, 1);
    endtask

    // After the last beat: idle gap, frame_done pulse, then settle timing.
    // rst_k > 0 asserts reset rst_k cycles after the frame_done cycle.
    task automatic finish_frame(input int gap, input int rst_k);
        for (int g = 0; g <= gap; g++) begin
            @(negedge clk_in);
            start = 1'b0;
            ready = ($urandom_range(0, 1) == 1);
            fdone = 1'b0;
            #1;
            chk_quiet("wait_frame");
            chk("wait_frame_dv_a", 32'(dv_a), 0);
            chk("wait_frame_dv_b", 32'(dv_b), 0);
        end
        @(negedge clk_in);
        fdone = 1'b1;
        #1;
        chk("fdone_cycle_dv_a", 32'(dv_a), 0);
        chk("fdone_cycle_dv_b", 32'(dv_b), 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_in);
            fdone = (k == 2);
            if (k == rst_k) rst_in = 1'b1;
            #1;
            if (rst_in) begin
                chk_quiet("rst_async");
                chk("rst_async_dv_a", 32'(dv_a), 0);
                chk("rst_async_dv_b", 32'(dv_b), 0);
                chk("rst_async_pd_a", 32'(pd_a), 0);
                chk("rst_async_pa_a", 32'(pa_a), 0);
            end else begin
                chk("settle_dv_a", 32'(dv_a), 32'(k >= SA + 1));
                chk("settle_dv_b", 32'(dv_b), 1);
                chk_quiet("settle");
            end
        end
    endtask

    initial begin
        int s, c, m, ab;
        rst_in = 1'b1;
        sel    = '0;
        start  = 1'b0;
        comp   = 1'b0;
        ready  = 1'b1;
        fdone  = 1'b0;
        repeat (2) @(negedge clk_in);
        #1;
        chk_quiet("reset");
        chk("reset_dv_a", 32'(dv_a), 0);
        chk("reset_dv_b", 32'(dv_b), 0);
        chk("reset_pd_a", 32'(pd_a), 0);
        chk("reset_pa_b", 32'(pa_b), 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // frame_done ignored while idle
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            fdone = (k == 0);
            #1;
            chk_quiet("idle");
            chk("idle_dv_a", 32'(dv_a), 0);
            chk("idle_dv_b", 32'(dv_b), 0);
        end

        // sel=0, ready high
        start_frame(0, 0);
        collect(0, 0, 0, N);
        finish_frame(1, 0);

        // sel=2, ready toggling
        start_frame(2, 0);
        collect(2, 0, 1, N);
        finish_frame(0, 0);

        // restart from SHOWN with sel=1
        start_frame(1, 0);
        collect(1, 0, 0, N);
        finish_frame(2, 0);

        // abort at beat 2, restart with sel=2
        start_frame(0, 0);
        collect(0, 0, 0, 2);
        @(negedge clk_in);
        #1;
        chk("abort_pre_addr", 32'(pa_a), 2);
        chk("abort_pre_last", 32'(pl_a), 0);
        start_frame(2, 0);
        collect(2, 0, 0, N);
        finish_frame(0, 0);

        // out-of-range select, random ready
        start_frame(3, 0);
        collect(3, 0, 2, N);
        finish_frame(1, 0);

        // reset mid-settle, then nothing until a full new frame
        start_frame(1, 0);
        collect(1, 0, 0, N);
        finish_frame(0, 2);
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            fdone = (k % 3 == 0);
            #1;
            chk_quiet("post_rst");
            chk("post_rst_dv_a", 32'(dv_a), 0);
            chk("post_rst_dv_b", 32'(dv_b), 0);
        end
        fdone = 1'b0;
        start_frame(0, 0);
        collect(0, 0, 2, N);
        finish_frame(0, 0);

        // randomized frames, with occasional aborts
        for (int f = 0; f < 8; f++) begin
            s = $urandom_range(0, (1 << SW) - 1);
`ifdef CALIB_COMPLEMENT_PASS_EN
            c = $urandom_range(0, 1);
`else
            c = 0;
`endif
            m  = $urandom_range(0, 2);
            ab = $urandom_range(0, 3);
            start_frame(s, c);
            if (ab >= 1 && ab <= 3) begin
                collect(s, c, m, ab);
                s = $urandom_range(0, (1 << SW) - 1);
                start_frame(s, c);
            end
            collect(s, c, m, N);
            finish_frame($urandom_range(0, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
